// File: rtl/interval_timer_if.sv
// Control/status bundle for interval_timer: the master drives commands,
// the slave (the timer) returns count and status.
interface interval_timer_if #(
  parameter int unsigned WIDTH = 27
) ();

  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic             tc_load;
  logic [WIDTH-1:0] tc_value;
  logic [WIDTH-1:0] count;
  logic             done;
  logic             expired;
  logic             busy;

  modport master (
    output start, stop, pause, mode, tc_load, tc_value,
    input  count, done, expired, busy
  );

  modport slave (
    input  start, stop, pause, mode, tc_load, tc_value,
    output count, done, expired, busy
  );

endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer with prescaler, one-shot/periodic modes,
// pause and abort; one-cycle done pulse per interval, sticky expired in one-shot.
module interval_timer #(
  parameter int unsigned WIDTH      = 27,
  parameter int unsigned DEFAULT_TC = 100_000_000,
  parameter int unsigned PRESCALE   = 1
) (
  input logic           clk,
  input logic           rst_n,
  interval_timer_if.slave bus
);

  localparam int unsigned    PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    EXPIRED
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] tc_q;
  logic [PW-1:0]    presc_q;
  logic             mode_q;
  logic             done_q;
  logic             expired_q;

  logic presc_wrap;
  logic count_last;
  logic tc_accept;

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign count_last = (count_q == tc_q - 1'b1);
  // A running interval never changes length; zero would make the interval undefined.
  assign tc_accept  = bus.tc_load && !bus.start && (bus.tc_value != '0) &&
                      ((state_q == IDLE) || (state_q == EXPIRED));

  // NOTE: every state register is updated with <= so all of them see the
  // pre-edge values, and every one gets an explicit async reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      tc_q      <= WIDTH'(DEFAULT_TC);
      presc_q   <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tc_accept) tc_q <= bus.tc_value;

      if (bus.stop) begin
        state_q   <= IDLE;
        count_q   <= '0;
        presc_q   <= '0;
        expired_q <= 1'b0;
      end else if (bus.start) begin
        state_q   <= RUN;
        count_q   <= '0;
        presc_q   <= '0;
        expired_q <= 1'b0;
        mode_q    <= bus.mode;
      end else if ((state_q == RUN) || (state_q == HOLD)) begin
        if (bus.pause) begin
          state_q <= HOLD;
        end else begin
          // Leaving HOLD counts on the same edge, so a pause costs exactly its length.
          state_q <= RUN;
          if (presc_wrap) begin
            presc_q <= '0;
            if (count_last) begin
              count_q <= '0;
              done_q  <= 1'b1;
              if (!mode_q) begin
                state_q   <= EXPIRED;
                expired_q <= 1'b1;
              end
            end else begin
              count_q <= count_q + 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;
  assign bus.busy    = (state_q == RUN) || (state_q == HOLD);

endmodule
